// File: rtl/morse_symbol_sequencer_pkg.sv
// Shared definitions for the Morse symbol sequencer: symbol codes, unit
// multipliers and FSM state encoding.
package morse_symbol_sequencer_pkg;

  // Symbol codes delivered by the 16:1 symbol mux.
  localparam logic [2:0] SYM_END  = 3'b000;
  localparam logic [2:0] SYM_DOT  = 3'b001;
  localparam logic [2:0] SYM_DASH = 3'b010;
  localparam logic [2:0] SYM_LGAP = 3'b011;
  localparam logic [2:0] SYM_WGAP = 3'b100;

  // Lengths in Morse units.
  localparam logic [2:0] DOT_UNITS  = 3'd1;
  localparam logic [2:0] DASH_UNITS = 3'd3;
  localparam logic [2:0] LGAP_UNITS = 3'd3;
  localparam logic [2:0] WGAP_UNITS = 3'd7;
  localparam logic [2:0] IGAP_UNITS = 3'd1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StMark,
    StSpace,
    StIgap,
    StFin,
    StRgap
  } state_e;

  // Number of units a timed symbol lasts; non-timed codes map to one unit.
  function automatic logic [2:0] unit_mult(logic [2:0] sym);
    logic [2:0] n;
    case (sym)
      SYM_DOT:  n = DOT_UNITS;
      SYM_DASH: n = DASH_UNITS;
      SYM_LGAP: n = LGAP_UNITS;
      SYM_WGAP: n = WGAP_UNITS;
      default:  n = IGAP_UNITS;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/morse_symbol_sequencer_if.sv
// Handshake/bus bundle between the character source (symbol mux + start
// logic) and the Morse sequencer. The repetir line exists only when
// MORSE_REPEAT_EN is defined.
interface morse_symbol_sequencer_if;
  logic       start;
  logic [2:0] simbolo;
  logic [3:0] sel;
  logic       key_out;
  logic       busy;
  logic       done;
`ifdef MORSE_REPEAT_EN
  logic       repetir;

  modport master (
    output start, simbolo, repetir,
    input  sel, key_out, busy, done
  );

  modport slave (
    input  start, simbolo, repetir,
    output sel, key_out, busy, done
  );
`else
  modport master (
    output start, simbolo,
    input  sel, key_out, busy, done
  );

  modport slave (
    input  start, simbolo,
    output sel, key_out, busy, done
  );
`endif
endinterface

// File: rtl/morse_symbol_sequencer_unit_timer.sv
// Prescaler plus unit counter. A load arms the timer for n_i units; expire_o
// is high during the last of the n_i*UNIT_CYCLES cycles after the load edge,
// so a state entered on the load edge lasts exactly that long.
module morse_symbol_sequencer_unit_timer #(
  parameter int unsigned UNIT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [2:0] n_i,
  output logic       expire_o
);

  localparam int unsigned PreW = $clog2(UNIT_CYCLES);
  localparam logic [PreW-1:0] PreLast = PreW'(UNIT_CYCLES - 1);

  logic [PreW-1:0] pre_q, pre_d;
  logic [2:0]      unit_q, unit_d;
  logic [2:0]      n_q, n_d;
  logic            active_q, active_d;

  logic last_pre, last_unit;
  assign last_pre  = (pre_q == PreLast);
  assign last_unit = (unit_q == (n_q - 3'd1));
  assign expire_o  = active_q && last_pre && last_unit;

  // Next-state: a load restarts counting even on the expiring cycle.
  always_comb begin
    pre_d    = pre_q;
    unit_d   = unit_q;
    n_d      = n_q;
    active_d = active_q;
    if (load_i) begin
      pre_d    = '0;
      unit_d   = '0;
      n_d      = n_i;
      active_d = 1'b1;
    end else if (active_q) begin
      if (last_pre) begin
        pre_d = '0;
        if (last_unit) begin
          active_d = 1'b0;
        end else begin
          unit_d = unit_q + 3'd1;
        end
      end else begin
        pre_d = pre_q + PreW'(1);
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q    <= '0;
      unit_q   <= '0;
      n_q      <= '0;
      active_q <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      unit_q   <= unit_d;
      n_q      <= n_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Morse symbol sequencer: walks symbol slots 1..MAX_SLOTS of the selected
// character through the symbol mux and produces the keyed carrier waveform.
// Optional feature macro: MORSE_REPEAT_EN (adds repetir, loops the character
// with a word gap between repetitions).
module morse_symbol_sequencer
  import morse_symbol_sequencer_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 50_000_000,
  parameter int unsigned MAX_SLOTS   = 12
) (
  input logic                        clk,
  input logic                        rst,
  morse_symbol_sequencer_if.slave    bus
);

  localparam logic [3:0] LastSel = 4'(MAX_SLOTS);

  state_e     state_q, state_d;
  logic [3:0] sel_q, sel_d;
  logic       key_q, busy_q, done_q;

  logic       tmr_load;
  logic [2:0] tmr_n;
  logic       tmr_expire;

  morse_symbol_sequencer_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmr_load),
    .n_i      (tmr_n),
    .expire_o (tmr_expire)
  );

  // Next state, select and timer control; timed states load the timer on entry.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    tmr_load = 1'b0;
    tmr_n    = IGAP_UNITS;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          sel_d   = 4'd1;
          state_d = StFetch;
        end
      end
      StFetch: begin
        case (bus.simbolo)
          SYM_DOT, SYM_DASH: begin
            state_d  = StMark;
            tmr_load = 1'b1;
            tmr_n    = unit_mult(bus.simbolo);
          end
          SYM_LGAP, SYM_WGAP: begin
            state_d  = StSpace;
            tmr_load = 1'b1;
            tmr_n    = unit_mult(bus.simbolo);
          end
          default: state_d = StFin;
        endcase
      end
      StMark: begin
        if (tmr_expire) begin
          state_d  = StIgap;
          tmr_load = 1'b1;
          tmr_n    = IGAP_UNITS;
        end
      end
      StIgap, StSpace: begin
        if (tmr_expire) begin
          if (sel_q == LastSel) begin
            state_d = StFin;
          end else begin
            sel_d   = sel_q + 4'd1;
            state_d = StFetch;
          end
        end
      end
      StFin: begin
        sel_d   = 4'd0;
        state_d = StIdle;
`ifdef MORSE_REPEAT_EN
        if (bus.repetir) begin
          state_d  = StRgap;
          tmr_load = 1'b1;
          tmr_n    = WGAP_UNITS;
        end
`endif
      end
      StRgap: begin
        if (tmr_expire) begin
          sel_d   = 4'd1;
          state_d = StFetch;
        end
      end
      default: begin
        sel_d   = 4'd0;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= 4'd0;
      key_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      key_q   <= (state_d == StMark);
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StFin);
    end
  end

  assign bus.sel     = sel_q;
  assign bus.key_out = key_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Self-checking bench for morse_symbol_sequencer with UNIT_CYCLES=4.
// A timeline model derived from the symbol rules predicts every output cycle.
module tb_morse_symbol_sequencer;

  localparam int unsigned U        = 4;
  localparam int unsigned MaxSlots = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  morse_symbol_sequencer_if bus ();

  // Behavioural symbol mux.
  logic [2:0] slot_mem [16];
  assign bus.simbolo = slot_mem[bus.sel];

  morse_symbol_sequencer #(
    .UNIT_CYCLES (U),
    .MAX_SLOTS   (MaxSlots)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       key;
    logic [3:0] sel;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    logic [2:0] s1;
    logic [2:0] s2;
    logic [2:0] s3;
    int         highs;
    int         len;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t observe();
    return {bus.key_out, bus.sel, bus.busy, bus.done};
  endfunction

  function automatic int mult(input logic [2:0] c);
    case (c)
      3'b001:  return 1;
      3'b010:  return 3;
      3'b011:  return 3;
      3'b100:  return 7;
      default: return 0;
    endcase
  endfunction

  // Expected per-cycle outputs starting with the cycle after start is taken.
  task automatic build_expect(input int passes);
    int s;
    logic [2:0] c;
    exp_q.delete();
    for (int p = 0; p < passes; p++) begin
      s = 1;
      exp_q.push_back({1'b0, 4'(s), 1'b1, 1'b0});
      forever begin
        c = slot_mem[s];
        if (c == 3'b001 || c == 3'b010) begin
          repeat (mult(c) * U) exp_q.push_back({1'b1, 4'(s), 1'b1, 1'b0});
          repeat (U) exp_q.push_back({1'b0, 4'(s), 1'b1, 1'b0});
        end else if (c == 3'b011 || c == 3'b100) begin
          repeat (mult(c) * U) exp_q.push_back({1'b0, 4'(s), 1'b1, 1'b0});
        end else begin
          break;
        end
        if (s == MaxSlots) break;
        s++;
        exp_q.push_back({1'b0, 4'(s), 1'b1, 1'b0});
      end
      exp_q.push_back({1'b0, 4'(s), 1'b1, 1'b1});
      if (p < passes - 1) begin
        repeat (7 * U) exp_q.push_back({1'b0, 4'd0, 1'b1, 1'b0});
      end
    end
    repeat (2) exp_q.push_back({1'b0, 4'd0, 1'b0, 1'b0});
  endtask

  task automatic run_seq(input int passes, input bit mid_start,
                         output int highs, output int len, output int max_sel);
    obs_t o;
    int   mid_idx;
    int   done_seen;
    build_expect(passes);
    highs     = 0;
    len       = -1;
    max_sel   = 0;
    done_seen = 0;
    mid_idx   = mid_start ? int'($urandom_range(1, exp_q.size() - 3)) : -1;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      o = observe();
      check("cycle", 32'(o), 32'(exp_q[i]));
      if (o.key) highs++;
      if (int'(o.sel) > max_sel) max_sel = int'(o.sel);
`ifdef MORSE_REPEAT_EN
      if (done_seen > 0 && !o.done) bus.repetir = 1'b0;
`endif
      if (o.done) begin
        done_seen++;
        if (len < 0) len = i + 1;
      end
      if (i == mid_idx) bus.start = 1'b1;
    end
    bus.start = 1'b0;
  endtask

  task automatic clear_slots();
    for (int k = 0; k < 16; k++) slot_mem[k] = (k > MaxSlots) ? 3'b001 : 3'b000;
  endtask

  vec_t vecs[7];
  int   highs, len, max_sel;
  int   r;

  initial begin
    vecs[0] = '{3'b001, 3'b000, 3'b000,  4, 11};
    vecs[1] = '{3'b010, 3'b011, 3'b000, 12, 32};
    vecs[2] = '{3'b110, 3'b001, 3'b001,  0,  2};
    vecs[3] = '{3'b100, 3'b001, 3'b000,  4, 40};
    vecs[4] = '{3'b001, 3'b010, 3'b000, 16, 28};
    vecs[5] = '{3'b000, 3'b001, 3'b001,  0,  2};
    vecs[6] = '{3'b111, 3'b001, 3'b000,  0,  2};

    bus.start = 1'b0;
`ifdef MORSE_REPEAT_EN
    bus.repetir = 1'b0;
`endif
    clear_slots();

    // Reset held three cycles.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset sel", 32'(bus.sel), 32'd0);
    check("reset key", 32'(bus.key_out), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    rst = 1'b0;

    // Directed table.
    foreach (vecs[v]) begin
      clear_slots();
      slot_mem[1] = vecs[v].s1;
      slot_mem[2] = vecs[v].s2;
      slot_mem[3] = vecs[v].s3;
      run_seq(1, 1'b0, highs, len, max_sel);
      check("vec key-high cycles", 32'(highs), 32'(vecs[v].highs));
      check("vec length to done", 32'(len), 32'(vecs[v].len));
    end

    // All twelve slots carry a dot; sel must stop at 12.
    clear_slots();
    for (int k = 1; k <= MaxSlots; k++) slot_mem[k] = 3'b001;
    run_seq(1, 1'b0, highs, len, max_sel);
    check("12 dots high cycles", 32'(highs), 32'd48);
    check("12 dots length", 32'(len), 32'd109);
    check("12 dots max sel", 32'(max_sel), 32'd12);

    // Random characters, some with a stray start pulse mid-sequence.
    for (int t = 0; t < 15; t++) begin
      clear_slots();
      for (int k = 1; k <= MaxSlots; k++) begin
        r = int'($urandom_range(0, 11));
        if (r < 4)       slot_mem[k] = 3'b001;
        else if (r < 6)  slot_mem[k] = 3'b010;
        else if (r < 8)  slot_mem[k] = 3'b011;
        else if (r < 9)  slot_mem[k] = 3'b100;
        else if (r < 10) slot_mem[k] = 3'b000;
        else if (r < 11) slot_mem[k] = 3'(5 + $urandom_range(0, 2));
        else             slot_mem[k] = 3'b001;
      end
      run_seq(1, t[0], highs, len, max_sel);
      check("random max sel in range", 32'(max_sel <= MaxSlots), 32'd1);
    end

`ifdef MORSE_REPEAT_EN
    // One dot repeated once with a 28-cycle word gap, then back to idle.
    clear_slots();
    slot_mem[1] = 3'b001;
    bus.repetir = 1'b1;
    run_seq(2, 1'b0, highs, len, max_sel);
    check("repeat high cycles", 32'(highs), 32'd8);
    check("repeat first done", 32'(len), 32'd11);
    bus.repetir = 1'b0;
`endif

    // Reset in the middle of a dash.
    clear_slots();
    slot_mem[1] = 3'b010;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("dash key before reset", 32'(bus.key_out), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid-dash reset key", 32'(bus.key_out), 32'd0);
    check("mid-dash reset sel", 32'(bus.sel), 32'd0);
    check("mid-dash reset busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle after reset key", 32'(bus.key_out), 32'd0);
    check("idle after reset busy", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
